clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
Parametrised programmable clock/strobe generator. Successor to the team's fixed 16-bit toggle divider. Adds a configurable counter width, three output modes (toggle, single-cycle pulse, PWM), a shadow-register load that either waits for a period boundary or applies immediately, and a per-period tick output. It is a fabric-side enable/strobe source, fully synchronous to one clock edge; its outputs must not be used as a clock net.

Parameters:
WIDTH, 16, width of the divisor, high-time and counter registers
RST_DIV, 0, divisor loaded by reset
RST_HI, 0, PWM high-time loaded by reset
RST_MODE, 2'b00, mode loaded by reset

Ports:
clk  in  1  single clock; all logic on rising edge only
rst  in  1  asynchronous, active-high reset
EN  in  1  run enable
PL  in  1  load strobe; captures Din, Din_hi, MODE, IMM into the shadow registers
Din  in  WIDTH  divisor D; period is D+1 cycles
Din_hi  in  WIDTH  PWM high time H, in cycles
MODE  in  2  00 toggle, 01 pulse, 10 pwm, 11 reserved
IMM  in  1  1 = apply load immediately (restart); 0 = apply at next period boundary
clk_out  out  1  generated output, registered
tick  out  1  one-cycle strobe, once per period, registered
load_pend  out  1  shadow holds a load not yet applied

Behaviour:
Registers:
- Active: per, hi, mode.
- Shadow: sh_per, sh_hi, sh_mode, sh_imm.
- Control: cnt[WIDTH], run, load_pend.

Reset (asynchronous):
- per = sh_per = RST_DIV; hi = sh_hi = RST_HI; mode = sh_mode = RST_MODE.
- cnt = 0, run = 0, load_pend = 0, clk_out = 0, tick = 0.

Start value S(mode, hi):
- toggle: 1
- pulse: 0
- pwm: (hi != 0)
- reserved: 0

Load capture:
- PL=1 at an edge (any EN state): shadow <= {Din, Din_hi, MODE, IMM}; load_pend <= 1.
- A later PL before the transfer overwrites the shadow.
- Transfer is always evaluated on the pre-edge register contents. A PL arriving on the same edge as a transfer refills the shadow and keeps load_pend = 1.

Transfer (load_pend=1; active <= shadow; load_pend <= 0) happens when any of:
- (a) run=0
- (b) sh_imm=1: restart, so cnt <= 0, clk_out <= S(new), tick <= 0
- (c) run=1 and cnt==per: normal wrap, evaluated with the new per/hi/mode. If the new mode is toggle and the old mode was not toggle, clk_out <= 1.

Per-edge operation, priority top to bottom:
- EN=0: run <= 0, cnt <= 0, clk_out <= 0, tick <= 0.
- EN=1, run=0 (start): run <= 1, cnt <= 0, clk_out <= S, tick <= 0.
- EN=1, run=1, cnt==per (wrap): cnt <= 0, tick <= 1, and
  - toggle: clk_out <= ~clk_out
  - pulse: clk_out <= 1
  - pwm: clk_out <= (hi != 0)
  - reserved: clk_out <= 0
- EN=1, run=1, cnt!=per: cnt <= cnt+1, tick <= 0, and
  - toggle: clk_out holds
  - pulse: clk_out <= 0
  - pwm: clk_out <= (cnt+1 < hi)
  - reserved: clk_out <= 0

Resulting waveforms:
- Toggle: half-period D+1 cycles, output period 2(D+1). D=0 gives clk/2.
- Pulse: clk_out == tick; high 1 cycle of every D+1. D=0 gives clk_out constantly 1 after the start cycle.
- PWM: high H cycles of D+1. H=0 gives always 0; H>D gives always 1.
- tick: first assertion D+1 cycles after the start edge; 0 during the start cycle.

Boundary rules:
- cnt never exceeds per, because comparison is equality.
- If a transfer lowers per below the current cnt, the transfer itself resets cnt to 0 (only cases b and c can occur while running).
- Arithmetic is unsigned WIDTH-bit. For per = 2^WIDTH-1, cnt reaches all-ones and then wraps to 0 through the equality path; no overflow path exists.
- Reset mid-period: outputs clear immediately (asynchronous), pending load is discarded, and active registers return to the parameter defaults.

Test Plan:
- Reset, then PL Din=3 MODE=00 IMM=0 with EN=0; raise EN -> load applied while idle; clk_out=1 for 4 cycles, 0 for 4 cycles, repeating; tick high every 4th cycle; load_pend=0.
- PWM: D=4, H=2, EN=1 -> clk_out pattern 1,1,0,0,0 repeating. Repeat with H=0 -> constant 0; with H=7 -> constant 1.
- Pulse: D=0 -> clk_out=1 every cycle after the start cycle. Then deferred load D=2 mid-period: load_pend=1 until the wrap, then one 1 every 3 cycles.
- Deferred vs immediate: running toggle D=9 at cnt=3, PL D=1 IMM=0 -> old period completes (cnt reaches 9), then half-period 2. Same stimulus with IMM=1 -> next edge cnt=0, clk_out=1, tick=0.
- PL coincident with a pending transfer at a wrap -> the old shadow is applied and the new values stay pending (load_pend=1) until the next wrap.
- Assert rst mid-period (WIDTH=16, D=16'hFFFF) -> clk_out, tick and load_pend go 0 asynchronously; after release the defaults are active. Also run a full 65536-cycle period to confirm the wrap at all-ones.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// Bus between a controller and the programmable clock/strobe generator.
// Holds the run/load controls, the load payload and the generated outputs.
interface clk_div_gen_if #(
  parameter int unsigned WIDTH = 16
);
  logic             EN;
  logic             PL;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Din_hi;
  logic [1:0]       MODE;
  logic             IMM;
  logic             clk_out;
  logic             tick;
  logic             load_pend;

  modport master (
    output EN, PL, Din, Din_hi, MODE, IMM,
    input  clk_out, tick, load_pend
  );

  modport slave (
    input  EN, PL, Din, Din_hi, MODE, IMM,
    output clk_out, tick, load_pend
  );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable strobe generator: toggle, single-cycle pulse or PWM output.
// New settings go through a shadow register and apply on a period boundary or at once.
module clk_div_gen #(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] RST_DIV  = '0,
  parameter logic [WIDTH-1:0] RST_HI   = '0,
  parameter logic [1:0]       RST_MODE = 2'b00
) (
  input logic          clk,
  input logic          rst,
  clk_div_gen_if.slave bus
);

  localparam logic [1:0] M_TOGGLE = 2'b00;
  localparam logic [1:0] M_PULSE  = 2'b01;
  localparam logic [1:0] M_PWM    = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0] per;
    logic [WIDTH-1:0] hi;
    logic [1:0]       mode;
  } cfg_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam cfg_t CFG_RST = '{per: RST_DIV, hi: RST_HI, mode: RST_MODE};

  state_t           state_q, state_d;
  cfg_t             act_q, act_d;
  cfg_t             sh_q, sh_d;
  cfg_t             eff;
  logic             sh_imm_q, sh_imm_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             at_wrap;
  logic             xfer;
  logic             restart;

  // Output level on the first cycle after a start or an immediate restart.
  function automatic logic start_val(input cfg_t c);
    logic v;
    v = 1'b0;
    case (c.mode)
      M_TOGGLE: v = 1'b1;
      M_PWM:    v = (c.hi != '0);
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: running follows the enable.
  always_comb begin
    state_d = state_q;
    if (bus.EN) state_d = S_RUN;
    else        state_d = S_IDLE;
  end

  // Output/datapath next values; transfer decisions use pre-edge contents only.
  always_comb begin
    at_wrap   = (state_q == S_RUN) && (cnt_q == act_q.per);
    xfer      = pend_q && ((state_q == S_IDLE) || sh_imm_q || at_wrap);
    restart   = xfer && sh_imm_q;
    eff       = xfer ? sh_q : act_q;
    cnt_inc   = cnt_q + WIDTH'(1);

    act_d     = eff;
    sh_d      = sh_q;
    sh_imm_d  = sh_imm_q;
    pend_d    = pend_q && !xfer;
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    if (bus.PL) begin
      sh_d.per  = bus.Din;
      sh_d.hi   = bus.Din_hi;
      sh_d.mode = bus.MODE;
      sh_imm_d  = bus.IMM;
      pend_d    = 1'b1;
    end

    if (bus.EN) begin
      if (state_q == S_IDLE || restart) begin
        clk_out_d = start_val(eff);
      end else if (at_wrap) begin
        tick_d = 1'b1;
        case (eff.mode)
          M_TOGGLE: clk_out_d = (xfer && act_q.mode != M_TOGGLE) ? 1'b1 : ~clk_out_q;
          M_PULSE:  clk_out_d = 1'b1;
          M_PWM:    clk_out_d = (eff.hi != '0);
          default:  clk_out_d = 1'b0;
        endcase
      end else begin
        cnt_d = cnt_inc;
        case (eff.mode)
          M_TOGGLE: clk_out_d = clk_out_q;
          M_PWM:    clk_out_d = (cnt_inc < eff.hi);
          default:  clk_out_d = 1'b0;
        endcase
      end
    end
  end

  // Configuration, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= CFG_RST;
      sh_q      <= CFG_RST;
      sh_imm_q  <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      act_q     <= act_d;
      sh_q      <= sh_d;
      sh_imm_q  <= sh_imm_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.load_pend = pend_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: mode waveforms, deferred/immediate loads,
// coincident loads, all-ones period wrap and asynchronous reset.
module tb_clk_div_gen;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  clk_div_gen_if #(.WIDTH(WIDTH)) bus ();

  clk_div_gen #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stop, load a configuration while idle, then start; returns just after the start edge.
  task automatic start_cfg(input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] hi,
                           input logic [1:0] mode);
    bus.EN = 1'b0;
    step();
    bus.PL = 1'b1; bus.Din = din; bus.Din_hi = hi; bus.MODE = mode; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    bus.EN = 1'b1;
    step();
  endtask

  // Compare n cycles of clk_out/tick against bit patterns; bit k is cycle k (k=0 is now).
  task automatic run_pat(input string nm, input logic [15:0] out_pat,
                         input logic [15:0] tick_pat, input int n);
    for (int k = 0; k < n; k++) begin
      if (k != 0) step();
      check($sformatf("%s_out[%0d]", nm, k), 32'(bus.clk_out), 32'(out_pat[k]));
      check($sformatf("%s_tick[%0d]", nm, k), 32'(bus.tick), 32'(tick_pat[k]));
    end
  endtask

  initial begin
    int  n;
    logic found;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.EN = 1'b0; bus.PL = 1'b0; bus.Din = '0; bus.Din_hi = '0;
    bus.MODE = 2'b00; bus.IMM = 1'b0;
    #12;
    check("rst_out",  32'(bus.clk_out),   32'd0);
    check("rst_tick", 32'(bus.tick),      32'd0);
    check("rst_pend", 32'(bus.load_pend), 32'd0);
    rst = 1'b0;

    // Toggle D=3 loaded while idle, then enabled
    bus.PL = 1'b1; bus.Din = 16'd3; bus.MODE = 2'b00; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    check("idle_pend", 32'(bus.load_pend), 32'd1);
    check("idle_out",  32'(bus.clk_out),   32'd0);
    bus.EN = 1'b1;
    step();
    run_pat("tog3", 16'h0F0F, 16'h1110, 16);
    check("tog3_pend", 32'(bus.load_pend), 32'd0);

    // PWM D=4 with H=2, 0, 7
    start_cfg(16'd4, 16'd2, 2'b10);
    run_pat("pwm_h2", 16'h0063, 16'h0020, 10);
    start_cfg(16'd4, 16'd0, 2'b10);
    run_pat("pwm_h0", 16'h0000, 16'h0020, 10);
    start_cfg(16'd4, 16'd7, 2'b10);
    run_pat("pwm_h7", 16'h03FF, 16'h0020, 10);

    // Pulse D=0, then deferred load D=2
    start_cfg(16'd0, 16'd0, 2'b01);
    run_pat("pul0", 16'h003E, 16'h003E, 6);
    bus.PL = 1'b1; bus.Din = 16'd2; bus.MODE = 2'b01; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    check("pul_def_pend", 32'(bus.load_pend), 32'd1);
    step();
    check("pul_def_pend2", 32'(bus.load_pend), 32'd0);
    run_pat("pul2", 16'h0049, 16'h0049, 7);

    // Deferred load into a running toggle D=9
    start_cfg(16'd9, 16'd0, 2'b00);
    repeat (3) step();
    bus.PL = 1'b1; bus.Din = 16'd1; bus.MODE = 2'b00; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    check("def_pend", 32'(bus.load_pend), 32'd1);
    run_pat("def", 16'h033F, 16'h0540, 11);
    check("def_pend_end", 32'(bus.load_pend), 32'd0);

    // Same stimulus with immediate apply
    start_cfg(16'd9, 16'd0, 2'b00);
    repeat (3) step();
    bus.PL = 1'b1; bus.Din = 16'd1; bus.MODE = 2'b00; bus.IMM = 1'b1;
    step();
    bus.PL = 1'b0; bus.IMM = 1'b0;
    check("imm_pend", 32'(bus.load_pend), 32'd1);
    step();
    check("imm_pend2", 32'(bus.load_pend), 32'd0);
    run_pat("imm", 16'h0003, 16'h0004, 3);

    // PL coincident with a pending transfer at a wrap
    start_cfg(16'd3, 16'd0, 2'b01);
    step();
    bus.PL = 1'b1; bus.Din = 16'd1; bus.MODE = 2'b01; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    step();
    bus.PL = 1'b1; bus.Din = 16'd4; bus.MODE = 2'b00; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    check("coin_out4",  32'(bus.clk_out),   32'd1);
    check("coin_tick4", 32'(bus.tick),      32'd1);
    check("coin_pend4", 32'(bus.load_pend), 32'd1);
    step();
    check("coin_out5",  32'(bus.clk_out),   32'd0);
    check("coin_pend5", 32'(bus.load_pend), 32'd1);
    step();
    check("coin_pend6", 32'(bus.load_pend), 32'd0);
    run_pat("coin", 16'h001F, 16'h0021, 6);

    // Full all-ones period: first tick 65536 cycles after start
    start_cfg(16'hFFFF, 16'd0, 2'b00);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      step();
      n++;
      if (bus.tick) found = 1'b1;
    end
    check("wrap_found", 32'(found), 32'd1);
    check("wrap_len", 32'(n), 32'd65536);
    check("wrap_out", 32'(bus.clk_out), 32'd0);

    // Asynchronous reset mid-period with a pending load
    start_cfg(16'hFFFF, 16'd0, 2'b00);
    repeat (100) step();
    check("mid_out", 32'(bus.clk_out), 32'd1);
    bus.PL = 1'b1; bus.Din = 16'd5; bus.MODE = 2'b01; bus.IMM = 1'b0;
    step();
    bus.PL = 1'b0;
    check("mid_pend", 32'(bus.load_pend), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out",  32'(bus.clk_out),   32'd0);
    check("arst_tick", 32'(bus.tick),      32'd0);
    check("arst_pend", 32'(bus.load_pend), 32'd0);
    #10;
    rst = 1'b0;
    step();
    run_pat("dflt", 16'h0015, 16'h001E, 5);
    check("dflt_pend", 32'(bus.load_pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
